// File: rtl/rx_dsc_defer_queue_manager_if.sv
// Packet stream bundle for the RX descriptor defer queue manager.
// Handshake: a beat moves on a rising clk edge where valid && ready are both
// high. Once valid is raised, the producer keeps valid and every payload
// field stable until that edge. ready may change freely and does not depend
// on valid on the same side.
// The "master" modport is the packet source and result sink. The "slave"
// modport is the manager itself.
interface rx_dsc_defer_queue_manager_if #(
  parameter int QID_W  = 6,
  parameter int PTR_W  = 16,
  parameter int META_W = 128
);
  logic [META_W-1:0] in_meta_data;
  logic              in_needs_dsc;
  logic [QID_W-1:0]  in_queue_id;
  logic              in_valid;
  logic              in_ready;

  logic [META_W-1:0] out_meta_data;
  logic              out_needs_dsc;
  logic [QID_W-1:0]  out_queue_id;
  logic [PTR_W-1:0]  out_tail;
  logic              out_deferred;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_meta_data, in_needs_dsc, in_queue_id, in_valid, out_ready,
    input  in_ready, out_meta_data, out_needs_dsc, out_queue_id, out_tail,
           out_deferred, out_valid
  );

  modport slave (
    input  in_meta_data, in_needs_dsc, in_queue_id, in_valid, out_ready,
    output in_ready, out_meta_data, out_needs_dsc, out_queue_id, out_tail,
           out_deferred, out_valid
  );
endinterface

// File: rtl/rx_dsc_defer_queue_manager.sv
// RX descriptor defer queue manager.
// Allocates ring slots per queue for packets that need a descriptor.
// When a ring is full, the packet is forwarded without a descriptor and the
// queue is marked pending. Once software frees a slot, a deferred,
// packet-less descriptor beat is emitted.
module rx_dsc_defer_queue_manager #(
  parameter int NB_QUEUES = 64,
  parameter int PTR_W     = 16,
  parameter int META_W    = 128,
  parameter int DEFER_EN  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  rx_dsc_defer_queue_manager_if.slave  bus,
  input  logic                         head_wr_valid,
  input  logic [$clog2(NB_QUEUES)-1:0] head_wr_queue_id,
  input  logic [PTR_W-1:0]             head_wr_ptr,
  input  logic [PTR_W:0]               rb_size,
  output logic [31:0]                  full_cnt,
  output logic [31:0]                  deferred_cnt
);
  localparam int QID_W = $clog2(NB_QUEUES);

  // Per-queue ring state.
  logic [PTR_W-1:0]     r_tail [NB_QUEUES];
  logic [PTR_W-1:0]     r_head [NB_QUEUES];
  logic [NB_QUEUES-1:0] r_pending;

  // Held low through reset so in_ready stays low until the first edge after release.
  logic r_run;

  // Output register stage.
  logic              r_out_valid;
  logic [META_W-1:0] r_out_meta;
  logic              r_out_needs;
  logic [QID_W-1:0]  r_out_qid;
  logic [PTR_W-1:0]  r_out_tail;
  logic              r_out_def;

  logic [31:0] r_full_cnt;
  logic [31:0] r_def_cnt;

  logic [PTR_W-1:0]     w_mask;
  logic [NB_QUEUES-1:0] w_full_vec;
  logic                 w_sel_found;
  logic [QID_W-1:0]     w_sel_qid;
  logic                 w_load;
  logic                 w_def_go;
  logic                 w_in_ready;
  logic                 w_in_fire;
  logic                 w_in_full;
  logic                 w_in_alloc;
  logic                 w_in_over;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p,
                                             input logic [PTR_W-1:0] m);
    return (p + 1'b1) & m;
  endfunction

  // The ring size is a power of two, so modulo reduces to a mask.
  assign w_mask = PTR_W'(rb_size - 1'b1);

  // A queue is full when advancing its tail would land on its head.
  always_comb begin
    w_full_vec = '0;
    for (int q = 0; q < NB_QUEUES; q++) begin
      w_full_vec[q] = (f_inc(r_tail[q], w_mask) == r_head[q]);
    end
  end

  // Pick the lowest-index queue that is pending and has room again.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_qid   = '0;
    for (int q = 0; q < NB_QUEUES; q++) begin
      if (!w_sel_found && r_pending[q] && !w_full_vec[q]) begin
        w_sel_found = 1'b1;
        w_sel_qid   = QID_W'(q);
      end
    end
  end

  // A deferred beat takes the output slot ahead of new input.
  // The full check uses the registered head, so a head write in the same
  // cycle is seen only from the next cycle onward.
  assign w_load     = !r_out_valid || bus.out_ready;
  assign w_def_go   = r_run && w_load && w_sel_found;
  assign w_in_ready = r_run && w_load && !w_sel_found;
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_in_full  = w_full_vec[bus.in_queue_id];
  assign w_in_alloc = w_in_fire && bus.in_needs_dsc && !w_in_full;
  assign w_in_over  = w_in_fire && bus.in_needs_dsc && w_in_full;

  // Run flag: rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_run <= 1'b0;
    else      r_run <= 1'b1;
  end

  // Ring pointers and pending flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int q = 0; q < NB_QUEUES; q++) begin
        r_tail[q] <= '0;
        r_head[q] <= '0;
      end
      r_pending <= '0;
    end else begin
      if (head_wr_valid) r_head[head_wr_queue_id] <= head_wr_ptr;
      if (w_def_go) begin
        r_tail[w_sel_qid]    <= f_inc(r_tail[w_sel_qid], w_mask);
        r_pending[w_sel_qid] <= 1'b0;
      end else if (w_in_alloc) begin
        r_tail[bus.in_queue_id] <= f_inc(r_tail[bus.in_queue_id], w_mask);
      end else if (w_in_over && (DEFER_EN != 0)) begin
        r_pending[bus.in_queue_id] <= 1'b1;
      end
    end
  end

  // Output register: load a deferred beat, an input beat, or empty on consume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_meta  <= '0;
      r_out_needs <= 1'b0;
      r_out_qid   <= '0;
      r_out_tail  <= '0;
      r_out_def   <= 1'b0;
    end else if (w_def_go) begin
      r_out_valid <= 1'b1;
      r_out_meta  <= '0;
      r_out_needs <= 1'b1;
      r_out_qid   <= w_sel_qid;
      r_out_tail  <= r_tail[w_sel_qid];
      r_out_def   <= 1'b1;
    end else if (w_in_fire) begin
      r_out_valid <= 1'b1;
      r_out_meta  <= bus.in_meta_data;
      r_out_needs <= w_in_alloc;
      r_out_qid   <= bus.in_queue_id;
      r_out_tail  <= w_in_alloc ? r_tail[bus.in_queue_id] : '0;
      r_out_def   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b0;
    end
  end

  // Event counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full_cnt <= '0;
      r_def_cnt  <= '0;
    end else begin
      if (w_in_over) r_full_cnt <= r_full_cnt + 32'd1;
      if (w_def_go)  r_def_cnt  <= r_def_cnt + 32'd1;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_meta_data = r_out_meta;
  assign bus.out_needs_dsc = r_out_needs;
  assign bus.out_queue_id  = r_out_qid;
  assign bus.out_tail      = r_out_tail;
  assign bus.out_deferred  = r_out_def;
  assign full_cnt          = r_full_cnt;
  assign deferred_cnt      = r_def_cnt;
endmodule

// File: doc/rx_dsc_defer_queue_manager.md
RX_DSC_DEFER_QUEUE_MANAGER -- requirements
Module: rx_dsc_defer_queue_manager

Interface
REQ-001 Parameter NB_QUEUES, default 64, number of RX descriptor queues (power of two, 2..1024).
REQ-002 Parameter PTR_W, default 16, descriptor ring pointer width; QID_W = $clog2(NB_QUEUES).
REQ-003 Parameter META_W, default 128, width of opaque per-packet metadata carried through.
REQ-004 Parameter DEFER_EN, default 1; 1 = defer descriptor on full ring, 0 = suppress descriptor only.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 in_meta_data  in  META_W  packet metadata.
REQ-008 in_needs_dsc  in  1  packet requests a descriptor; 0 = pass-through.
REQ-009 in_queue_id  in  QID_W  target descriptor queue.
REQ-010 in_valid / in_ready  in / out  1  input handshake.
REQ-011 out_meta_data  out  META_W  forwarded metadata; all-zero for deferred descriptors.
REQ-012 out_needs_dsc  out  1  a descriptor is to be written at out_tail.
REQ-013 out_queue_id  out  QID_W  queue of the output beat.
REQ-014 out_tail  out  PTR_W  ring slot the descriptor occupies.
REQ-015 out_deferred  out  1  beat is a deferred descriptor with no packet.
REQ-016 out_valid / out_ready  out / in  1  output handshake.
REQ-017 head_wr_valid, head_wr_queue_id, head_wr_ptr  in  1, QID_W, PTR_W  software head update.
REQ-018 rb_size  in  PTR_W+1  ring size in entries, power of two, >= 2.
REQ-019 full_cnt, deferred_cnt  out  32, 32  event counters.

Function
REQ-020 Per-queue state: tail[PTR_W], head[PTR_W], pending[1]; all pointer arithmetic is modulo rb_size using mask (rb_size-1).
REQ-021 Queue q is full when ((tail[q]+1) & (rb_size-1)) == head[q].
REQ-022 The single output register stage gives latency 1 cycle from accepted input to out_valid.
REQ-023 The output register loads when !out_valid || out_ready; in_ready = that condition && no deferred beat is selected that cycle.
REQ-024 out_valid is held and all out_* are stable until out_ready is sampled high.
REQ-025 Pass-through (in_needs_dsc=0): metadata is forwarded with out_needs_dsc=0, out_deferred=0, and no state changes.
REQ-026 Descriptor request on a non-full queue: out_needs_dsc=1, out_tail=tail[q], and tail[q] is incremented modulo rb_size.
REQ-027 Descriptor request on a full queue: metadata is forwarded with out_needs_dsc=0, full_cnt increments, tail is unchanged, and pending[q] is set when DEFER_EN=1.
REQ-028 head_wr_valid writes head[q] in the same cycle; the new value is visible to full checks from the next cycle.
REQ-029 Queue q is eligible when pending[q]=1 and q is not full; the lowest-index eligible queue is selected.
REQ-030 A selected deferred beat has priority over input when the output register can load.
REQ-031 A deferred beat emits out_deferred=1, out_needs_dsc=1, out_meta_data=0, and out_tail=tail[q]; tail[q] increments, pending[q] clears, and deferred_cnt increments.
REQ-032 pending is a single bit per queue: multiple full events on one queue before release yield exactly one deferred descriptor.
REQ-033 When input and head update hit the same queue in the same cycle, the full check uses the pre-update head.
REQ-034 When pending is set and a head update hits the same queue in the same cycle, eligibility is evaluated next cycle.
REQ-035 Tail wraps from rb_size-1 to 0; the counters wrap at 2^32.
REQ-036 Changing rb_size is legal only while in_valid=0 and out_valid=0 with all pending clear; behaviour is otherwise undefined.

Reset
REQ-037 While rst=0: tail, head, pending, full_cnt and deferred_cnt are 0, out_valid=0, in_ready=0, and all other out_* are 0.
REQ-038 Reset assertion mid-transfer drops the in-flight output beat and all pending deferrals; in_ready rises on the first clk edge after release.

Verification
REQ-039 rb_size=4, q=3: three descriptor packets -> out_tail 0,1,2 with out_needs_dsc=1; the fourth -> out_needs_dsc=0 and full_cnt=1.
REQ-040 Continuing REQ-039: head_wr q=3 ptr=1 -> deferred beat on q=3 with out_tail=3, out_meta_data=0, deferred_cnt=1, and tail then wraps to 0.
REQ-041 Two full events on q=5, then head freed -> exactly one deferred beat; pending[5]=0 afterwards.
REQ-042 out_ready held low for 5 cycles with in_valid=1 -> in_ready=0 and out_* stable; on release, beats arrive in order with no loss or duplication.
REQ-043 DEFER_EN=0: full event then head update -> no deferred beat and deferred_cnt stays 0.
REQ-044 Assert rst while out_valid=1 and pending[2]=1 -> all outputs 0; after release, a descriptor to q=2 gets out_tail=0 and no deferred beat appears.
